// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated-window frequency counter with BCD result and scanned digit output
// Optional leading-zero blanking on bcd_out: define FREQ_METER_BLANK_EN.
module freq_meter #(
    parameter int CLK_HZ   = 50000000,
    parameter int GATE_MS  = 1000,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4096
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            en,
    input  logic                                            sig_in,
    output logic [4*DIGITS-1:0]                             value,
    output logic                                            valid,
    output logic                                            overflow,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]  digit_sel,
    output logic [3:0]                                      bcd_out
);

    localparam int GATE_CYC = CLK_HZ / 1000 * GATE_MS;
    localparam int GATE_W   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W    = 4 * DIGITS;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(DIGITS - 1);
    localparam logic [VAL_W-1:0]  ACC_ONE   = VAL_W'(1);

    typedef enum logic [1:0] {IDLE, WARM, MEASURE} state_t;

    state_t             state_q, state_d;
    logic               sync1, sync2, sync3;
    logic               edge_det;
    logic [GATE_W-1:0]  gate_cnt;
    logic               terminal;
    logic               run;
    logic               latch;
    logic [VAL_W-1:0]   acc;
    logic [VAL_W-1:0]   acc_inc;
    logic               acc_ovf;
    logic               all_nines;
    logic               carry;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [3:0]         bcd_next;

    assign edge_det = sync2 & ~sync3;
    assign terminal = (gate_cnt == GATE_LAST);
    assign run      = en && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WARM;
                WARM:    if (terminal) state_d = MEASURE;
                MEASURE: latch = terminal;
                default: state_d = IDLE;
            endcase
        end
    end

    // Cascaded decimal increment; all_nines marks the saturation point.
    always_comb begin
        acc_inc   = acc;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (acc[4*i +: 4] == 4'd9) begin
                    acc_inc[4*i +: 4] = 4'd0;
                end else begin
                    acc_inc[4*i +: 4] = acc[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            gate_cnt <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            value    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
            valid <= latch;
            if (latch) begin
                value    <= acc;
                overflow <= acc_ovf;
            end
            if (!run) begin
                gate_cnt <= '0;
                acc      <= '0;
                acc_ovf  <= 1'b0;
            end else if (terminal) begin
                // An edge in the terminal cycle belongs to the window now opening.
                gate_cnt <= '0;
                acc      <= edge_det ? ACC_ONE : '0;
                acc_ovf  <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                if (edge_det) begin
                    if (all_nines) acc_ovf <= 1'b1;
                    else           acc     <= acc_inc;
                end
            end
        end
    end

`ifdef FREQ_METER_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              zero_above;

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (value[4*i +: 4] == 4'd0);
            blank[i]   = zero_above && (i != 0);
        end
        bcd_next = blank[digit_sel] ? 4'hF : value[4*int'(digit_sel) +: 4];
    end
`else
    always_comb begin
        bcd_next = value[4*int'(digit_sel) +: 4];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_sel <= '0;
            bcd_out   <= 4'd0;
        end else begin
            bcd_out <= bcd_next;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_sel <= (digit_sel == SEL_LAST) ? '0 : digit_sel + SEL_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, sig_in;
    logic [7:0] value;
    logic       valid, overflow;
    logic [0:0] digit_sel;
    logic [3:0] bcd_out;

    logic       rst_nb, en_b, sig_b;
    logic [7:0] value_b;
    logic       valid_b, overflow_b;
    logic [0:0] digit_sel_b;
    logic [3:0] bcd_out_b;

    freq_meter #(.CLK_HZ(1000), .GATE_MS(10), .DIGITS(2), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .value(value), .valid(valid), .overflow(overflow),
        .digit_sel(digit_sel), .bcd_out(bcd_out)
    );

    freq_meter #(.CLK_HZ(1000), .GATE_MS(1000), .DIGITS(2), .SCAN_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_nb), .en(en_b), .sig_in(sig_b),
        .value(value_b), .valid(valid_b), .overflow(overflow_b),
        .digit_sel(digit_sel_b), .bcd_out(bcd_out_b)
    );

    typedef struct {
        int         edges;
        logic [7:0] exp_value;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   toggle_a = 1'b0;

`ifdef FREQ_METER_BLANK_EN
    localparam logic [3:0] HI_DIGIT = 4'hF;
`else
    localparam logic [3:0] HI_DIGIT = 4'h0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_a) sig_in = ~sig_in;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid_a(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (valid) return;
        end
        n = -1;
    endtask

    task automatic wait_valid_b(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (valid_b) return;
        end
        n = -1;
    endtask

    initial begin
        int n;
        int run;
        logic [0:0] prev_sel;
        bit seen_change;

        vecs[0] = '{1,   8'h01, 1'b0};
        vecs[1] = '{9,   8'h09, 1'b0};
        vecs[2] = '{10,  8'h10, 1'b0};
        vecs[3] = '{37,  8'h37, 1'b0};
        vecs[4] = '{99,  8'h99, 1'b0};
        vecs[5] = '{100, 8'h99, 1'b1};
        vecs[6] = '{499, 8'h99, 1'b1};
        vecs[7] = '{37,  8'h37, 1'b0};

        rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
        rst_nb = 1'b0; en_b = 1'b0; sig_b = 1'b0;
        repeat (3) tick();
        check("reset_value", value, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_digit_sel", digit_sel, 1'b0);
        check("reset_bcd_out", bcd_out, 4'h0);

        // Steady toggling: first result only after warm-up window plus one measured window
        en = 1'b1; en_b = 1'b1; toggle_a = 1'b1;
        rst_n = 1'b1; rst_nb = 1'b1;
        wait_valid_a(100, n);
        check("first_valid_latency", n, 21);
        check("toggle_value", value, 8'h05);
        check("toggle_overflow", overflow, 1'b0);
        tick();
        check("valid_one_cycle", valid, 1'b0);

        // Digit scan with value 05
        tick();
        prev_sel = digit_sel;
        run = 1;
        seen_change = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (digit_sel == prev_sel) begin
                run++;
                check("scan_bcd", bcd_out, (digit_sel == 1'b0) ? 4'h5 : HI_DIGIT);
            end else begin
                if (seen_change) check("scan_period", run, 4);
                seen_change = 1'b1;
                run = 1;
            end
            prev_sel = digit_sel;
        end

        // Asynchronous reset between clock edges
        n = 0;
        while (digit_sel != 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check("pre_reset_sel", digit_sel, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_value", value, 8'h00);
        check("async_valid", valid, 1'b0);
        check("async_overflow", overflow, 1'b0);
        check("async_digit_sel", digit_sel, 1'b0);
        check("async_bcd_out", bcd_out, 4'h0);
        tick();
        rst_n = 1'b1;
        wait_valid_a(100, n);
        check("post_reset_latency", n, 21);
        check("post_reset_value", value, 8'h05);

        // Edge aligned to the terminal cycle
        toggle_a = 1'b0;
        sig_in = 1'b0;
        repeat (5) tick();
        wait_valid_a(100, n);
        wait_valid_a(100, n);
        check("quiet_window", value, 8'h00);
        repeat (7) tick();
        sig_in = 1'b1;
        wait_valid_a(100, n);
        check("terminal_valid_at", n, 3);
        check("terminal_edge_excluded", value, 8'h00);
        sig_in = 1'b0;
        wait_valid_a(100, n);
        check("terminal_edge_next_window", value, 8'h01);
        repeat (6) tick();
        sig_in = 1'b1;
        wait_valid_a(100, n);
        check("pre_terminal_edge_counted", value, 8'h01);
        sig_in = 1'b0;

        // en dropped mid-window, raised three cycles later
        toggle_a = 1'b1;
        wait_valid_a(100, n);
        repeat (4) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_valid_a(100, n);
        check("en_restart_latency", n, 21);
        check("en_restart_value", value, 8'h05);

        // Long-gate instance: table of edge counts per window
        wait_valid_b(2100, n);
        check("b_first_valid_seen", n > 0, 1'b1);
        check("b_first_value", value_b, 8'h00);
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].edges; k++) begin
                sig_b = 1'b1;
                tick();
                sig_b = 1'b0;
                tick();
            end
            wait_valid_b(1100, n);
            check($sformatf("b_valid_seen_%0d", v), n > 0, 1'b1);
            check($sformatf("b_value_%0d", v), value_b, vecs[v].exp_value);
            check($sformatf("b_overflow_%0d", v), overflow_b, vecs[v].exp_ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
